// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load, plus a burst
// serializer that loads a word and streams all WIDTH bits out under start/busy/done.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] q_shr, q_shl;

  assign q_shr = {sin_r, q[WIDTH-1:1]};
  assign q_shl = {q[WIDTH-2:0], sin_l};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // done is a pulse: it falls on every edge unless the last burst shift raises it.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            q_nxt     = pin;
            dir_nxt   = dir;
            cnt_nxt   = CW'(WIDTH);
            busy_nxt  = 1'b1;
            state_nxt = BURST;
          end else begin
            case (mode)
              2'b01:   q_nxt = q_shr;
              2'b10:   q_nxt = q_shl;
              2'b11:   q_nxt = pin;
              default: q_nxt = q;
            endcase
          end
        end
        BURST: begin
          q_nxt   = dir_q ? q_shl : q_shr;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign pout   = q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] pin;
  logic         start;
  logic         dir;
  logic [W-1:0] pout;
  logic         sout_r;
  logic         sout_l;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .start  (start),
    .dir    (dir),
    .pout   (pout),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'($urandom);
    mode  = 2'($urandom);
    sin_r = 1'($urandom);
    sin_l = 1'($urandom);
    pin   = W'($urandom);
    start = 1'($urandom);
    dir   = 1'($urandom);
    step();
    n_cmp++;
    if (pout !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_pout: got %h want 00", pout);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_done: got %b want 0", done);
    end
    rst_n = 1'b1; en = 1'b1; mode = 2'b00; start = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; dir = 1'b0; pin = '0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    en = 1'b1; pin = 8'h96; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || pout !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midrst_after: got busy=%b done=%b pout=%h want 0 0 00", busy, done, pout);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midrst_no_done: got busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_manual();
    logic [7:0] siso;
    siso = 8'b0000_0101;
    en = 1'b1; start = 1'b0;
    mode = 2'b11; pin = 8'hA5;
    step();
    n_cmp++;
    if (pout !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL load_A5: got %h want A5", pout);
    end
    mode = 2'b01; sin_r = 1'b1;
    step();
    n_cmp++;
    if (pout !== 8'hD2) begin
      n_fail++;
      $display("[TB] FAIL shr_D2: got %h want D2", pout);
    end
    mode = 2'b10; sin_l = 1'b0;
    step();
    n_cmp++;
    if (pout !== 8'hA4) begin
      n_fail++;
      $display("[TB] FAIL shl_A4: got %h want A4", pout);
    end
    mode = 2'b00; pin = 8'hFF; sin_r = 1'b1; sin_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (pout !== 8'hA4) begin
        n_fail++;
        $display("[TB] FAIL hold_A4: got %h want A4", pout);
      end
    end
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      sin_r = siso[i];
      step();
    end
    n_cmp++;
    if (pout !== 8'h05) begin
      n_fail++;
      $display("[TB] FAIL siso_fill: got %h want 05", pout);
    end
    sin_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sout_r !== siso[i]) begin
        n_fail++;
        $display("[TB] FAIL siso_out[%0d]: got %b want %b", i, sout_r, siso[i]);
      end
      step();
    end
    mode = 2'b00;
  endtask

  task automatic test_right_burst();
    logic [7:0] got;
    int busy_cnt, done_cnt, done_at;
    got = '0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    en = 1'b1; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b1;
    pin = 8'h96; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    got[0] = sout_r;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c < 8) got[c] = sout_r;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
    end
    n_cmp++;
    if (got !== 8'h96) begin
      n_fail++;
      $display("[TB] FAIL rburst_data: got %h want 96", got);
    end
    n_cmp++;
    if (busy_cnt != 8) begin
      n_fail++;
      $display("[TB] FAIL rburst_busy_len: got %0d want 8", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 8) begin
      n_fail++;
      $display("[TB] FAIL rburst_done: got count=%0d at=%0d want 1 at 8", done_cnt, done_at);
    end
    n_cmp++;
    if (pout !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL rburst_fill: got %h want 00", pout);
    end
  endtask

  task automatic test_left_burst_stalls();
    logic [7:0] got;
    logic [7:0] prev;
    int busy_cnt, done_cnt, done_at, n;
    got = '0; busy_cnt = 0; done_cnt = 0; done_at = -1; n = 0;
    en = 1'b1; mode = 2'b00; sin_r = 1'b1; sin_l = 1'b0;
    pin = 8'h96; dir = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    got[7] = sout_l;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    for (int c = 1; c <= 13; c++) begin
      en = (c == 2 || c == 5) ? 1'b0 : 1'b1;
      prev = pout;
      step();
      if (!en) begin
        n_cmp++;
        if (pout !== prev || busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL lburst_stall_c%0d: got pout=%h busy=%b want %h 1", c, pout, busy, prev);
        end
      end else if (n < 7) begin
        n++;
        got[7-n] = sout_l;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
    end
    en = 1'b1;
    n_cmp++;
    if (got !== 8'h96) begin
      n_fail++;
      $display("[TB] FAIL lburst_data: got %h want 96", got);
    end
    n_cmp++;
    if (busy_cnt != 10) begin
      n_fail++;
      $display("[TB] FAIL lburst_busy_len: got %0d want 10", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 10) begin
      n_fail++;
      $display("[TB] FAIL lburst_done: got count=%0d at=%0d want 1 at 10", done_cnt, done_at);
    end
    n_cmp++;
    if (pout !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL lburst_fill: got %h want 00", pout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    got = '0;
    en = 1'b1; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
    pin = 8'h3C; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    got[0] = sout_r;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) begin
        mode = 2'b11; pin = 8'hFF; start = 1'b1; dir = 1'b1;
      end
      step();
      got[c] = sout_r;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL b2b_busy_c%0d: got busy=%b done=%b want 1 0", c, busy, done);
      end
    end
    n_cmp++;
    if (got !== 8'h3C) begin
      n_fail++;
      $display("[TB] FAIL b2b_data: got %h want 3C", got);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got busy=%b done=%b want 0 1", busy, done);
    end
    step();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || pout !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL b2b_restart: got busy=%b done=%b pout=%h want 1 0 FF", busy, done, pout);
    end
    start = 1'b0; mode = 2'b00; sin_r = 1'b1; sin_l = 1'b0; dir = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1 || pout !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got busy=%b done=%b pout=%h want 0 1 00", busy, done, pout);
    end
  endtask

  task automatic test_en_gating_idle();
    en = 1'b1; start = 1'b0; mode = 2'b11; pin = 8'h5A;
    step();
    en = 1'b0; pin = 8'hC3; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (pout !== 8'h5A || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL engate_hold: got pout=%h busy=%b want 5A 0", pout, busy);
      end
    end
    en = 1'b1; start = 1'b0; mode = 2'b00;
    step();
    n_cmp++;
    if (pout !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL engate_release: got pout=%h busy=%b want 5A 0", pout, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
    pin = '0; start = 1'b0; dir = 1'b0;
    step();
    test_reset();
    test_reset_mid_burst();
    test_manual();
    test_right_burst();
    test_left_burst_stalls();
    test_back_to_back();
    test_en_gating_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
